// File: rtl/sap_control_core.sv
// SAP-style CPU control core: fetch/execute sequencer, opcode decoder and accumulator ALU.
// Optional INC/DEC opcodes (9/A) are built only when CPU_INCDEC_EN is defined.
module sap_control_core #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              alu_enable,
  output logic              sub,
  output logic              inc_a,
  output logic              dec_a,
  output logic              c,
  output logic              z,
  output logic              pc_enable,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              mar_load,
  output logic              ram_read,
  output logic              ram_write,
  output logic              in_bus,
  output logic              out_bus,
  output logic              reg_load_a,
  output logic              reg_enable_a,
  output logic              reg_load_b,
  output logic              reg_enable_b,
  output logic              reg_load_o,
  output logic              fetch_complete,
  output logic [1:0]        step,
  output logic [1:0]        steps_required,
  output logic              halted
);

  typedef enum logic [1:0] {S_F0, S_F1, S_EXEC, S_HALT} state_t;

  localparam logic [DATA_W:0] ONE      = {{DATA_W{1'b0}}, 1'b1};
  localparam logic [DATA_W:0] ALL_ONES = {1'b0, {DATA_W{1'b1}}};

  state_t          state, state_nx;
  logic [1:0]      step_nx;
  logic [DATA_W:0] sum;

  // State register; flags only update on cycles where the ALU drives the bus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_F0;
      step  <= 2'd0;
      c     <= 1'b0;
      z     <= 1'b0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
      if (alu_enable) begin
        c <= sum[DATA_W];
        z <= (sum[DATA_W-1:0] == '0);
      end
    end
  end

  always_comb begin
    case (opcode)
      4'h1, 4'h4: steps_required = 2'd1;
      4'h2, 4'h3: steps_required = 2'd2;
      default:    steps_required = 2'd0;
    endcase
  end

  always_comb begin
    state_nx = state;
    step_nx  = step;
    case (state)
      S_F0: begin
        state_nx = S_F1;
        step_nx  = 2'd0;
      end
      S_F1: begin
        state_nx = S_EXEC;
        step_nx  = 2'd0;
      end
      S_EXEC: begin
        if (opcode == 4'hF) begin
          state_nx = S_HALT;
          step_nx  = 2'd0;
        end else if (step == steps_required) begin
          state_nx = S_F0;
          step_nx  = 2'd0;
        end else begin
          step_nx = step + 2'd1;
        end
      end
      default: begin
        state_nx = S_HALT;
        step_nx  = 2'd0;
      end
    endcase
  end

  // Strobes are held low through reset; fetch_complete/halted reflect the state register.
  always_comb begin
    alu_enable   = 1'b0;
    sub          = 1'b0;
    inc_a        = 1'b0;
    dec_a        = 1'b0;
    pc_enable    = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    mar_load     = 1'b0;
    ram_read     = 1'b0;
    ram_write    = 1'b0;
    in_bus       = 1'b0;
    out_bus      = 1'b0;
    reg_load_a   = 1'b0;
    reg_enable_a = 1'b0;
    reg_load_b   = 1'b0;
    reg_enable_b = 1'b0;
    reg_load_o   = 1'b0;
    fetch_complete = (state == S_EXEC);
    halted         = (state == S_HALT);
    if (rst) begin
      case (state)
        S_F0: begin
          pc_enable = 1'b1;
          mar_load  = 1'b1;
        end
        S_F1: begin
          ram_read = 1'b1;
          in_bus   = 1'b1;
          pc_inc   = 1'b1;
        end
        S_EXEC: begin
          case (opcode)
            4'h1, 4'h2, 4'h3, 4'h4: begin
              if (step == 2'd0) begin
                out_bus  = 1'b1;
                mar_load = 1'b1;
              end else if (step == 2'd1) begin
                ram_read     = (opcode != 4'h4);
                reg_load_a   = (opcode == 4'h1);
                reg_load_b   = (opcode == 4'h2) || (opcode == 4'h3);
                reg_enable_a = (opcode == 4'h4);
                ram_write    = (opcode == 4'h4);
              end else begin
                alu_enable = 1'b1;
                reg_load_a = 1'b1;
                sub        = (opcode == 4'h3);
              end
            end
            4'h5: begin
              out_bus    = 1'b1;
              reg_load_a = 1'b1;
            end
            4'h6: begin
              out_bus = 1'b1;
              pc_load = 1'b1;
            end
            4'h7: begin
              out_bus = c;
              pc_load = c;
            end
            4'h8: begin
              out_bus = z;
              pc_load = z;
            end
`ifdef CPU_INCDEC_EN
            4'h9: begin
              alu_enable = 1'b1;
              inc_a      = 1'b1;
              reg_load_a = 1'b1;
            end
            4'hA: begin
              alu_enable = 1'b1;
              dec_a      = 1'b1;
              reg_load_a = 1'b1;
            end
`endif
            4'hE: begin
              reg_enable_a = 1'b1;
              reg_load_o   = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Later assignments override earlier ones, giving inc > dec > sub > add.
  always_comb begin
    sum = sub ? ({1'b0, a} + {1'b0, ~b} + ONE) : ({1'b0, a} + {1'b0, b});
`ifdef CPU_INCDEC_EN
    if (dec_a) sum = {1'b0, a} + ALL_ONES;
    if (inc_a) sum = {1'b0, a} + ONE;
`endif
  end

  assign result = alu_enable ? sum[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_sap_control_core.sv
// Bench for sap_control_core: directed instruction sequences, expected output words
// queued per cycle and checked by an independent negedge monitor.
module tb_sap_control_core;
  localparam int W = 33;

  localparam logic [16:0] ALU = 17'h10000, SUB = 17'h08000, INC = 17'h04000, DEC = 17'h02000;
  localparam logic [16:0] PCE = 17'h01000, PCI = 17'h00800, PCL = 17'h00400, MAR = 17'h00200;
  localparam logic [16:0] RR  = 17'h00100, RW  = 17'h00080, IN  = 17'h00040, OB  = 17'h00020;
  localparam logic [16:0] LA  = 17'h00010, EA  = 17'h00008, LB  = 17'h00004, EB  = 17'h00002;
  localparam logic [16:0] LO  = 17'h00001, NONE = 17'h00000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic [7:0] result;
  logic alu_enable, sub, inc_a, dec_a, c, z, pc_enable, pc_inc, pc_load, mar_load;
  logic ram_read, ram_write, in_bus, out_bus, reg_load_a, reg_enable_a, reg_load_b;
  logic reg_enable_b, reg_load_o, fetch_complete, halted;
  logic [1:0] step, steps_required;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  logic         mc = 1'b0, mz = 1'b0;
  logic [W-1:0] obs;

  sap_control_core #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .a(a), .b(b), .result(result),
    .alu_enable(alu_enable), .sub(sub), .inc_a(inc_a), .dec_a(dec_a), .c(c), .z(z),
    .pc_enable(pc_enable), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .ram_read(ram_read), .ram_write(ram_write), .in_bus(in_bus), .out_bus(out_bus),
    .reg_load_a(reg_load_a), .reg_enable_a(reg_enable_a), .reg_load_b(reg_load_b),
    .reg_enable_b(reg_enable_b), .reg_load_o(reg_load_o), .fetch_complete(fetch_complete),
    .step(step), .steps_required(steps_required), .halted(halted)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  assign obs = {alu_enable, sub, inc_a, dec_a, pc_enable, pc_inc, pc_load, mar_load,
                ram_read, ram_write, in_bus, out_bus, reg_load_a, reg_enable_a,
                reg_load_b, reg_enable_b, reg_load_o, fetch_complete, halted,
                step, steps_required, result, c, z};

  function automatic logic [1:0] sr_of(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 2'd1;
      4'h2, 4'h3: return 2'd2;
      default:    return 2'd0;
    endcase
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s: got strobes=%h fc=%b h=%b step=%0d sr=%0d res=%h c=%b z=%b expected strobes=%h fc=%b h=%b step=%0d sr=%0d res=%h c=%b z=%b",
                 nm, obs[32:16], obs[15], obs[14], obs[13:12], obs[11:10], obs[9:2], obs[1], obs[0],
                 e[32:16], e[15], e[14], e[13:12], e[11:10], e[9:2], e[1], e[0]);
      end
    end
  end

  // driver tasks
  task automatic tick(input string nm, input logic [16:0] s, input logic fc, input logic h,
                      input logic [1:0] st, input logic [7:0] res);
    exp_q.push_back({s, fc, h, st, sr_of(opcode), res, mc, mz});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] op);
    opcode = op;
    tick("f0", PCE | MAR, 1'b0, 1'b0, 2'd0, 8'h00);
    tick("f1", RR | IN | PCI, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic run_alu3(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] res, input logic nc, input logic nz);
    a = av;
    b = bv;
    fetch(op);
    tick("arith_e0", OB | MAR, 1'b1, 1'b0, 2'd0, 8'h00);
    tick("arith_e1", RR | LB, 1'b1, 1'b0, 2'd1, 8'h00);
    tick("arith_e2", ALU | LA | ((op == 4'h3) ? SUB : NONE), 1'b1, 1'b0, 2'd2, res);
    mc = nc;
    mz = nz;
  endtask

  task automatic run1(input string nm, input logic [3:0] op, input logic [16:0] s);
    fetch(op);
    tick(nm, s, 1'b1, 1'b0, 2'd0, 8'h00);
  endtask

  initial begin
    rst = 1'b0;
    @(posedge clk);
    #1;
    tick("reset", NONE, 1'b0, 1'b0, 2'd0, 8'h00);
    rst = 1'b1;
    run1("nop", 4'h0, NONE);

    run_alu3(4'h2, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0);
    run_alu3(4'h3, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1);
    run1("jz_taken", 4'h8, OB | PCL);
    run1("jc_taken", 4'h7, OB | PCL);
    run_alu3(4'h2, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
    run1("jc_not_taken", 4'h7, NONE);
    run1("jz_not_taken", 4'h8, NONE);

    fetch(4'h1);
    tick("lda_e0", OB | MAR, 1'b1, 1'b0, 2'd0, 8'h00);
    tick("lda_e1", RR | LA, 1'b1, 1'b0, 2'd1, 8'h00);
    fetch(4'h4);
    tick("sta_e0", OB | MAR, 1'b1, 1'b0, 2'd0, 8'h00);
    tick("sta_e1", EA | RW, 1'b1, 1'b0, 2'd1, 8'h00);
    run1("ldi", 4'h5, OB | LA);
    run1("jmp", 4'h6, OB | PCL);
    run1("out", 4'hE, EA | LO);
    run1("op_b", 4'hB, NONE);
    run1("op_d", 4'hD, NONE);

`ifdef CPU_INCDEC_EN
    a = 8'hFF;
    run1("inc_wrap", 4'h9, ALU | INC | LA);
    mc = 1'b0;
    mz = 1'b0;
    exp_q[exp_q.size()-1][9:2] = 8'h00;
    mc = 1'b1;
    mz = 1'b1;
    a = 8'h00;
    fetch(4'hA);
    tick("dec_wrap", ALU | DEC | LA, 1'b1, 1'b0, 2'd0, 8'hFF);
    mc = 1'b0;
    mz = 1'b0;
    run1("flags_after_dec", 4'h0, NONE);
`else
    a = 8'hFF;
    run1("op9_nop", 4'h9, NONE);
    run1("opA_nop", 4'hA, NONE);
`endif

    run_alu3(4'h2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    run1("jz_after_wrap", 4'h8, OB | PCL);

    // reset in the middle of an ADD, with both flags set
    a = 8'h03;
    b = 8'h04;
    fetch(4'h2);
    tick("mid_e0", OB | MAR, 1'b1, 1'b0, 2'd0, 8'h00);
    rst = 1'b0;
    tick("mid_reset", NONE, 1'b1, 1'b0, 2'd1, 8'h00);
    mc = 1'b0;
    mz = 1'b0;
    rst = 1'b1;
    run1("after_mid_reset", 4'h0, NONE);

    fetch(4'hF);
    tick("hlt_e0", NONE, 1'b1, 1'b0, 2'd0, 8'h00);
    for (int i = 0; i < 10; i++) tick("halt_hold", NONE, 1'b0, 1'b1, 2'd0, 8'h00);
    rst = 1'b0;
    tick("halt_reset", NONE, 1'b0, 1'b1, 2'd0, 8'h00);
    rst = 1'b1;
    run1("after_halt", 4'h0, NONE);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
